// File: rtl/wb_arbiter.sv
// Purpose: round-robin writeback arbiter feeding one registered CDB beat per cycle from NREQ one-entry slots.
// Latency: 2 cycles uncontended (handshake -> slot -> CDB register); a valid slot is granted within NREQ cycles.
// Backpressure: req_ready[i] drops while slot i is full and not granted this cycle, during rob_flush and during reset.
//
// Ports:
//   clk, rst                    clock and asynchronous active-low reset
//   req_valid/req_ready         per-requester handshake
//   req_robid/req_rd/req_result/req_error  per-requester payload, packed with requester i in slice i
//   rob_flush                   drops every buffered entry and the next CDB beat, resets the pointer
//   wb_valid, wb_error, wb_robid, wb_rd, wb_result, wb_src  registered CDB beat
module wb_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_robid,
  input  logic [NREQ*6-1:0] req_rd,
  input  logic [NREQ*32-1:0] req_result,
  input  logic [NREQ-1:0]   req_error,
  input  logic              rob_flush,
  output logic              wb_valid,
  output logic              wb_error,
  output logic [7:0]        wb_robid,
  output logic [5:0]        wb_rd,
  output logic [31:0]       wb_result,
  output logic [IDXW-1:0]   wb_src
);

  typedef struct packed {
    logic        error;
    logic [7:0]  robid;
    logic [5:0]  rd;
    logic [31:0] result;
  } wb_dat_t;

  logic [NREQ-1:0] slot_vld;
  wb_dat_t         slot_dat [NREQ];
  logic [IDXW-1:0] rr_ptr;
  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW-1:0] cand;
  logic [NREQ-1:0] hs;

  // (base + off) mod NREQ, valid for off < NREQ; NREQ need not be a power of two.
  function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return sum[IDXW-1:0];
  endfunction

  // Search starts at rr_ptr so the most recently served requester goes last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = wrap_idx(rr_ptr, k);
      if (!grant_any && slot_vld[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
    if (rob_flush) begin
      grant_any = 1'b0;
      grant_idx = '0;
    end
    grant            = '0;
    grant[grant_idx] = grant_any;
  end

  // A slot being granted this cycle can take a new entry on the same edge,
  // which is what lets a lone requester stream at full rate.
  assign req_ready = rst ? ({NREQ{~rob_flush}} & (~slot_vld | grant)) : '0;
  assign hs        = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_vld  <= '0;
      rr_ptr    <= '0;
      wb_valid  <= 1'b0;
      wb_error  <= 1'b0;
      wb_robid  <= '0;
      wb_rd     <= '0;
      wb_result <= '0;
      wb_src    <= '0;
    end else if (rob_flush) begin
      slot_vld <= '0;
      rr_ptr   <= '0;
      wb_valid <= 1'b0;
    end else begin
      slot_vld <= (slot_vld & ~grant) | hs;
      wb_valid <= grant_any;
      if (grant_any) begin
        rr_ptr <= (grant_idx == IDXW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        wb_src <= grant_idx;
        {wb_error, wb_robid, wb_rd, wb_result} <= slot_dat[grant_idx];
      end
    end
  end

  // Payload needs no reset: it is only observed through slot_vld.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        slot_dat[i] <= {req_error[i], req_robid[8*i +: 8], req_rd[6*i +: 6], req_result[32*i +: 32]};
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int NREQ = 4;
  localparam int IDXW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*8-1:0]  req_robid;
  logic [NREQ*6-1:0]  req_rd;
  logic [NREQ*32-1:0] req_result;
  logic [NREQ-1:0]    req_error;
  logic               rob_flush;
  logic               wb_valid;
  logic               wb_error;
  logic [7:0]         wb_robid;
  logic [5:0]         wb_rd;
  logic [31:0]        wb_result;
  logic [IDXW-1:0]    wb_src;

  wb_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_robid(req_robid), .req_rd(req_rd), .req_result(req_result), .req_error(req_error),
    .rob_flush(rob_flush),
    .wb_valid(wb_valid), .wb_error(wb_error), .wb_robid(wb_robid),
    .wb_rd(wb_rd), .wb_result(wb_result), .wb_src(wb_src)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [7:0]  robid;
    logic [5:0]  rd;
    logic [31:0] res;
  } pl_t;

  typedef struct {
    int  src;
    pl_t p;
  } exp_t;

  // Reference model: per-requester slot contents plus a round-robin pointer.
  logic            m_v [NREQ];
  pl_t             m_p [NREQ];
  int              m_ptr;
  int              m_g;
  logic [NREQ-1:0] m_rdy;
  exp_t            exp_q[$];
  exp_t            mon_e;
  logic [NREQ-1:0] hsv;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: dut=%0h want=%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int m_pick();
    for (int k = 0; k < NREQ; k++) begin
      if (m_v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] m_ready();
    logic [NREQ-1:0] r;
    int g;
    r = '0;
    if (rst && !rob_flush) begin
      g = m_pick();
      for (int i = 0; i < NREQ; i++) r[i] = !m_v[i] || (i == g);
    end
    return r;
  endfunction

  // Model update at each edge; a grant pushes the beat the CDB must show next cycle.
  initial begin
    for (int i = 0; i < NREQ; i++) m_v[i] = 1'b0;
    m_ptr = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int i = 0; i < NREQ; i++) m_v[i] = 1'b0;
        m_ptr = 0;
        exp_q.delete();
      end else begin
        m_rdy = m_ready();
        m_g   = rob_flush ? -1 : m_pick();
        if (rob_flush) begin
          for (int i = 0; i < NREQ; i++) m_v[i] = 1'b0;
          m_ptr = 0;
        end else begin
          if (m_g >= 0) begin
            exp_q.push_back('{src: m_g, p: m_p[m_g]});
            m_v[m_g] = 1'b0;
            m_ptr    = (m_g + 1) % NREQ;
          end
          for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && m_rdy[i]) begin
              m_v[i] = 1'b1;
              m_p[i] = {req_error[i], req_robid[8*i +: 8], req_rd[6*i +: 6], req_result[32*i +: 32]};
            end
          end
        end
      end
    end
  end

  // Monitor: checks ready every cycle and pops the scoreboard whenever a beat is due.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("req_ready", req_ready, m_ready());
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("wb_valid", wb_valid, 1);
        check("wb_src", wb_src, mon_e.src);
        check("wb_payload", {wb_error, wb_robid, wb_rd, wb_result}, mon_e.p);
      end else begin
        check("wb_idle", wb_valid, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [7:0] robid, input logic [5:0] rd,
                      input logic [31:0] res, input logic err);
    req_valid[i]          = 1'b1;
    req_robid[8*i +: 8]   = robid;
    req_rd[6*i +: 6]      = rd;
    req_result[32*i +: 32] = res;
    req_error[i]          = err;
  endtask

  // Asserts reset between edges, checks the forced values, releases between edges.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst       = 1'b0;
    req_valid = '0;
    rob_flush = 1'b0;
    #1;
    check("rst_outputs_zero", {wb_valid, wb_error, wb_src, wb_robid, wb_rd, wb_result}, 0);
    check("rst_ready_zero", req_ready, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("ready_after_rst", req_ready, {NREQ{1'b1}});
    step();
  endtask

  initial begin
    rst        = 1'b0;
    req_valid  = '0;
    rob_flush  = 1'b0;
    req_robid  = '0;
    req_rd     = '0;
    req_result = '0;
    req_error  = '0;
    do_reset();

    // Single requester, uncontended latency.
    load(1, 8'h05, 6'd3, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check("t1_ready", req_ready[1], 1);
    step();
    req_valid = '0;
    step();
    @(negedge clk);
    check("t1_beat", {wb_valid, wb_src, wb_robid, wb_rd, wb_result},
          {1'b1, 2'd1, 8'h05, 6'd3, 32'hDEADBEEF});
    step();
    @(negedge clk);
    check("t1_idle", wb_valid, 0);

    // All requesters at once; includes no-destination and error entries.
    do_reset();
    load(0, 8'h20, 6'd1,  32'h1111_0000, 1'b0);
    load(1, 8'h21, 6'h20, 32'h2222_0000, 1'b0);
    load(2, 8'h22, 6'd7,  32'h3333_0000, 1'b1);
    load(3, 8'h23, 6'h3F, 32'h4444_0000, 1'b1);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t2_ready_cycle1", req_ready, 4'b0001);
    for (int k = 0; k < NREQ; k++) begin
      step();
      @(negedge clk);
      check("t2_src_order", {wb_valid, wb_src}, {1'b1, 2'(k)});
    end
    step();

    // Requester 2 streams alone at full rate.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      load(2, 8'h10 + 8'(k), 6'(k), $urandom, 1'b0);
      @(negedge clk);
      check("t3_ready_held", req_ready[2], 1);
      step();
    end
    req_valid = '0;
    repeat (4) step();

    // Flush while requesters 0 and 3 hold slots.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      req_valid = '0;
      rob_flush = (c == 4);
      if (c <= 5) begin
        load(0, 8'h40 + 8'(c), 6'd2, $urandom, 1'b0);
        load(3, 8'h48 + 8'(c), 6'd9, $urandom, 1'b0);
      end
      @(negedge clk);
      if (c == 4) check("t4_flush_no_ready", req_ready, 0);
      if (c == 5) check("t4_post_flush_idle", wb_valid, 0);
      if (c == 5) check("t4_slots_empty", req_ready, {NREQ{1'b1}});
      if (c == 7) check("t4_ptr_reset", {wb_valid, wb_src}, {1'b1, 2'd0});
      step();
    end
    req_valid = '0;
    rob_flush = 1'b0;

    // Reset mid-stream with three slots still full and a beat on the CDB.
    do_reset();
    for (int i = 0; i < NREQ; i++) load(i, 8'h30 + 8'(i), 6'(i), $urandom, 1'b0);
    step();
    req_valid = '0;
    step();
    do_reset();
    repeat (6) step();

    // Random traffic; a requester holds its entry until accepted.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      hsv = req_valid & req_ready;
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || hsv[i]) begin
          if ($urandom_range(0, 9) < 6) load(i, 8'($urandom), 6'($urandom), $urandom, ($urandom_range(0, 15) == 0));
          else req_valid[i] = 1'b0;
        end
      end
      rob_flush = ($urandom_range(0, 63) == 0);
    end
    req_valid = '0;
    rob_flush = 1'b0;
    repeat (NREQ + 4) step();
    @(negedge clk);
    check("drain_slots_empty", req_ready, {NREQ{1'b1}});
    check("drain_idle", wb_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
